pkt_marker_finder: RTL and testbench
====================================

PKT_MARKER_FINDER -- requirements
Module: pkt_marker_finder

Interface
REQ-001 SHALL have parameter LANES, default 16: lane count per beat, minimum 2.
REQ-002 SHALL have parameter LANE_W, default 16: bits per lane.
REQ-003 SHALL have parameter MARK_W, default 2: marker bits per lane, at lane bits [MARK_W-1:0], with 1 <= MARK_W <= LANE_W.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts the beat.
REQ-008 SHALL have port in_data, input, LANES*LANE_W bits: lane i occupies bits [LANE_W*i +: LANE_W].
REQ-009 SHALL have port in_last, input, 1 bit: final beat of frame.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_hits, output, LANES bits: per-lane hit flags.
REQ-013 SHALL have port out_last, output, 1 bit: registered copy of in_last.
REQ-014 SHALL have port hit_count, output, 32 bits: present only when PKT_FINDER_STATS_EN is defined.

Function
REQ-015 SHALL compute mark[i] = AND-reduction of lane i marker bits.
REQ-016 SHALL compute elig[0] = !carry_elig | carry_mark, and elig[i] = !elig[i-1] | mark[i-1] for i >= 1.
REQ-017 SHALL compute hits = elig & mark.
REQ-018 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid | out_ready, combinational.
REQ-019 SHALL register hits/in_last into out_hits/out_last on the accept cycle; latency exactly 1 cycle.
REQ-020 SHALL set out_valid on accept and clear it on out_valid && out_ready without a new accept; simultaneous accept and drain keeps out_valid=1 with new data (full throughput).
REQ-021 SHALL hold out_hits/out_last stable while out_valid && !out_ready.
REQ-022 SHALL use FSM frame state: IDLE (carry_elig=0, carry_mark=0) and ACTIVE (carry from last beat).
REQ-023 SHALL go IDLE->ACTIVE on accept with in_last=0, ACTIVE->ACTIVE on accept with in_last=0, and any state->IDLE on accept with in_last=1; there is no transition without an accept.
REQ-024 SHALL load carry_elig=elig[LANES-1] and carry_mark=mark[LANES-1] on every accept with in_last=0.
REQ-025 SHALL never update carry or state while stalled (no accept).

Reset
REQ-026 SHALL, with rst_n=0 at a clk edge, force out_valid=0, out_hits=0, out_last=0, state=IDLE, carry=0, hit_count=0.
REQ-027 SHALL drive in_ready=1 during and after reset; reset mid-frame discards the frame, and the next beat is treated as frame start.

Configuration
REQ-028 SHALL, with PKT_FINDER_STATS_EN defined, add hit_count, incremented by popcount(out_hits) on each output handshake, saturating at 32'hFFFF_FFFF.
REQ-029 SHALL, without PKT_FINDER_STATS_EN, omit the hit_count port and counter logic; all other behaviour is identical.

Structure
REQ-030 SHALL place frame_state_e (IDLE, ACTIVE) and default parameter constants in package pkt_finder_pkg.
REQ-031 SHALL implement the REQ-015..017 recurrence in combinational sub-module pkt_lane_chain (inputs mark vector, carry_elig, carry_mark; outputs elig, hits).

Verification (LANES=16, LANE_W=16, MARK_W=2)
REQ-032 SHALL cover: single-beat frame (in_last=1), marker 2'b11 in lanes 0 and 2 only -> out_hits=16'h0001 one cycle later.
REQ-033 SHALL cover: beat A in_last=0 with mark=16'h4000, then beat B with mark=16'h0001 -> A hits 16'h4000, B hits 16'h0000; B sent as a new frame gives 16'h0001.
REQ-034 SHALL cover: out_ready=0 for 3 cycles with result held -> in_ready=0, out_hits unchanged, carry/state unchanged, no beat lost or duplicated.
REQ-035 SHALL cover: all markers 2'b11 over back-to-back beats with out_ready=1 -> every out_hits=16'hFFFF at one beat per cycle.
REQ-036 SHALL cover: rst_n=0 for one cycle after an in_last=0 beat -> outputs zero, state IDLE; next beat with mark=16'h0001 -> 16'h0001.
REQ-037 SHALL cover, with PKT_FINDER_STATS_EN defined: hits 16'h0001, 16'h0000, 16'hFFFF drained -> hit_count=17; preload near max -> saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pkt_finder_pkg.sv
// Shared types and default parameters for the packet marker finder.
//   frame_state_e : frame tracking state (IDLE = frame start, ACTIVE = mid-frame)
//   DEF_*         : default lane geometry
package pkt_finder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_e;

  localparam int DEF_LANES  = 16;
  localparam int DEF_LANE_W = 16;
  localparam int DEF_MARK_W = 2;

endpackage

// File: rtl/pkt_lane_chain.sv
// Combinational lane eligibility chain.
// A lane is eligible when the previous lane was not eligible or carried a
// marker; lane 0 takes its "previous lane" from the carry of the last beat.
//   mark       : per-lane marker flags
//   carry_elig : eligibility of the last lane of the previous beat
//   carry_mark : marker flag of the last lane of the previous beat
//   elig       : per-lane eligibility
//   hits       : eligible lanes that carry a marker
module pkt_lane_chain
  import pkt_finder_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic [LANES-1:0] mark,
  input  logic             carry_elig,
  input  logic             carry_mark,
  output logic [LANES-1:0] elig,
  output logic [LANES-1:0] hits
);

  always_comb begin
    elig    = '0;
    elig[0] = ~carry_elig | carry_mark;
    for (int i = 1; i < LANES; i++) begin
      elig[i] = ~elig[i-1] | mark[i-1];
    end
  end

  assign hits = elig & mark;

endmodule

// File: rtl/pkt_marker_finder.sv
// Packet marker finder: flags marker lanes that are eligible under the lane
// chain rule, tracking the chain across beats of a frame.
// Optional feature macro: PKT_FINDER_STATS_EN adds the hit_count port.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input beat handshake
//   in_data, in_last    : lane data (lane i at [LANE_W*i +: LANE_W]), frame end
//   out_valid/out_ready : result handshake
//   out_hits, out_last  : per-lane hit flags, registered in_last
//   hit_count           : saturating total of handed-off hits (stats build only)
//
// state  | meaning
// IDLE   | next beat starts a frame, chain carry forced to zero
// ACTIVE | mid-frame, chain continues from the stored carry
module pkt_marker_finder
  import pkt_finder_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int MARK_W = DEF_MARK_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_hits,
  output logic                    out_last
`ifdef PKT_FINDER_STATS_EN
  ,
  output logic [31:0]             hit_count
`endif
);

  frame_state_e     state_q, state_d;
  logic             carry_elig_q, carry_elig_d;
  logic             carry_mark_q, carry_mark_d;
  logic [LANES-1:0] mark;
  logic [LANES-1:0] elig;
  logic [LANES-1:0] hits;
  logic             accept;
  logic             chain_elig;
  logic             chain_mark;
  logic             bits_unused;

  always_comb begin
    mark = '0;
    for (int i = 0; i < LANES; i++) begin
      mark[i] = &in_data[LANE_W*i +: MARK_W];
    end
  end

  // Only the marker field and the last lane's eligibility matter downstream.
  assign bits_unused = ^{in_data, elig};

  // Reset term keeps in_ready high while out_valid is being cleared.
  assign in_ready = ~rst_n | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign chain_elig = (state_q == ACTIVE) ? carry_elig_q : 1'b0;
  assign chain_mark = (state_q == ACTIVE) ? carry_mark_q : 1'b0;

  pkt_lane_chain #(.LANES(LANES)) u_chain (
    .mark       (mark),
    .carry_elig (chain_elig),
    .carry_mark (chain_mark),
    .elig       (elig),
    .hits       (hits)
  );

  always_comb begin
    state_d      = state_q;
    carry_elig_d = carry_elig_q;
    carry_mark_d = carry_mark_q;
    if (accept) begin
      if (in_last) begin
        state_d      = IDLE;
        carry_elig_d = 1'b0;
        carry_mark_d = 1'b0;
      end else begin
        state_d      = ACTIVE;
        carry_elig_d = elig[LANES-1];
        carry_mark_d = mark[LANES-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      carry_elig_q <= 1'b0;
      carry_mark_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      carry_elig_q <= carry_elig_d;
      carry_mark_q <= carry_mark_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hits  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_hits  <= hits;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PKT_FINDER_STATS_EN
  logic [32:0] count_sum;

  assign count_sum = {1'b0, hit_count} + 33'($countones(out_hits));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (out_valid && out_ready) begin
      hit_count <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_pkt_marker_finder.sv
// Scoreboard bench for pkt_marker_finder: a driver pushes reference results
// computed lane by lane over the frame's marker stream; a monitor pops and
// compares on each output handshake.
module tb_pkt_marker_finder;

  localparam int L  = 16;
  localparam int W  = 16;
  localparam int MW = 2;
  localparam int DW = L * W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [L-1:0]  out_hits;
  logic          out_last;
`ifdef PKT_FINDER_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   exp_cnt;
`endif

  pkt_marker_finder #(.LANES(L), .LANE_W(W), .MARK_W(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hits  (out_hits),
    .out_last  (out_last)
`ifdef PKT_FINDER_STATS_EN
    ,
    .hit_count (hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0] hits;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_elig;      // eligibility of the previous lane in the current frame
  bit   m_mark;      // marker of the previous lane in the current frame
  bit   acc_now;
  bit   acc_last;
  int   stall_cnt;
  bit   rand_ready;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference: walk the frame as one continuous stream of lanes. The first
  // lane of a frame is always eligible; after that a lane is eligible when
  // the lane before it was not eligible or was marked.
  task automatic model_beat(input logic [DW-1:0] d, input logic l, output logic [L-1:0] h);
    h = '0;
    for (int i = 0; i < L; i++) begin
      logic [W-1:0] lane;
      bit mk, el;
      lane = d[W*i +: W];
      mk   = (lane[MW-1:0] == {MW{1'b1}});
      el   = !m_elig || m_mark;
      h[i] = el && mk;
      m_elig = el;
      m_mark = mk;
    end
    if (l) begin
      m_elig = 1'b0;
      m_mark = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] mk_beat(input logic [L-1:0] marks);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < L; i++) begin
      logic [W-1:0] lane;
      lane = W'($urandom);
      if (marks[i]) lane[MW-1:0] = {MW{1'b1}};
      else if (lane[MW-1:0] == {MW{1'b1}}) lane[0] = 1'b0;
      d[W*i +: W] = lane;
    end
    return d;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic l, input bit use_want,
                      input logic [L-1:0] want, output int waits);
    logic [L-1:0] h;
    exp_t e;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    model_beat(d, l, h);
    e.hits = use_want ? want : h;
    e.last = l;
    sb.push_back(e);
    acc_now = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_now  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    m_elig = 1'b0;
    m_mark = 1'b0;
`ifdef PKT_FINDER_STATS_EN
    exp_cnt = '0;
`endif
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_hits", 64'(out_hits), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef PKT_FINDER_STATS_EN
    check("rst_hit_count", 64'(hit_count), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #3;
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(posedge clk) acc_last = acc_now;

  bit           held;
  logic [L-1:0] held_hits;
  logic         held_last;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (acc_last) check("latency_valid", 64'(out_valid), 64'(1));
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 64'(in_ready), 64'(0));
        if (held) begin
          check("hold_hits", 64'(out_hits), 64'(held_hits));
          check("hold_last", 64'(out_last), 64'(held_last));
        end
        held      = 1'b1;
        held_hits = out_hits;
        held_last = out_last;
      end else begin
        held = 1'b0;
      end
`ifdef PKT_FINDER_STATS_EN
      check("hit_count", 64'(hit_count), 64'(exp_cnt));
`endif
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got hits %0h, expected no output", out_hits);
        end else begin
          e = sb.pop_front();
          check("out_hits", 64'(out_hits), 64'(e.hits));
          check("out_last", 64'(out_last), 64'(e.last));
`ifdef PKT_FINDER_STATS_EN
          begin
            logic [32:0] s;
            s = {1'b0, exp_cnt} + 33'($countones(e.hits));
            exp_cnt = s[32] ? 32'hFFFF_FFFF : s[31:0];
          end
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    stall_cnt  = 0;
    rand_ready = 1'b0;
    acc_now    = 1'b0;
    acc_last   = 1'b0;
    held       = 1'b0;
    m_elig     = 1'b0;
    m_mark     = 1'b0;
`ifdef PKT_FINDER_STATS_EN
    exp_cnt    = '0;
`endif
    do_reset(2);

    // single-beat frame, markers in lanes 0 and 2
    send(mk_beat(16'h0005), 1'b1, 1'b1, 16'h0001, w);

    // carry across beats, then same beat as a fresh frame
    send(mk_beat(16'h4000), 1'b0, 1'b1, 16'h4000, w);
    send(mk_beat(16'h0001), 1'b1, 1'b1, 16'h0000, w);
    send(mk_beat(16'h0001), 1'b1, 1'b1, 16'h0001, w);

    // three-cycle backpressure between beats of one frame
    send(mk_beat(16'h4000), 1'b0, 1'b1, 16'h4000, w);
    stall_cnt = 3;
    send(mk_beat(16'h0001), 1'b1, 1'b1, 16'h0000, w);
    check("stall_wait_cycles", 64'(w), 64'(3));

    // all lanes marked, back to back
    for (int i = 0; i < 8; i++) begin
      send(mk_beat(16'hFFFF), (i == 7), 1'b1, 16'hFFFF, w);
      check("full_rate_waits", 64'(w), 64'(0));
    end

    // reset mid-frame discards the carry
    send(mk_beat(16'h0005), 1'b0, 1'b0, '0, w);
    do_reset(1);
    send(mk_beat(16'h0001), 1'b1, 1'b1, 16'h0001, w);
    drain();

`ifdef PKT_FINDER_STATS_EN
    do_reset(1);
    send(mk_beat(16'h0005), 1'b1, 1'b1, 16'h0001, w);
    send(mk_beat(16'h0000), 1'b1, 1'b1, 16'h0000, w);
    send(mk_beat(16'hFFFF), 1'b1, 1'b1, 16'hFFFF, w);
    drain();
    check("hit_count_17", 64'(hit_count), 64'(17));
`endif

    // random traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [L-1:0] marks;
      if ($urandom_range(0, 7) == 0) begin
        marks = '1;
      end else begin
        marks = '0;
        for (int i = 0; i < L; i++) marks[i] = ($urandom_range(0, 3) == 0);
      end
      send(mk_beat(marks), ($urandom_range(0, 3) == 0), 1'b0, '0, w);
    end
    rand_ready = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
